// File: rtl/fifo_pkg.sv
// Shared helpers for the async FIFO: Gray conversion and address-width derivation.
// Functions work on a 32-bit container; callers zero-extend and slice.
package fifo_pkg;

  function automatic int fifo_aw(input int depth);
    return (depth <= 1) ? 1 : $clog2(depth);
  endfunction

  function automatic logic [31:0] bin2gray(input logic [31:0] b);
    return b ^ (b >> 1);
  endfunction

  // Prefix XOR from the MSB down; zero-extended upper bits leave the result unchanged.
  function automatic logic [31:0] gray2bin(input logic [31:0] g);
    logic [31:0] b;
    b[31] = g[31];
    for (int i = 30; i >= 0; i--) b[i] = b[i+1] ^ g[i];
    return b;
  endfunction

endpackage

// File: rtl/sync_bus.sv
// Multi-flop synchronizer for a Gray-coded bus crossing into the local clock domain.
module sync_bus #(
  parameter int WIDTH  = 5,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [STAGES-1:0][WIDTH-1:0] sr;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) sr <= '0;
    else        sr <= {sr[STAGES-2:0], d};
  end

  assign q = sr[STAGES-1];

endmodule

// File: rtl/fifo_wr_ctrl.sv
// Write-side controller of the async FIFO: accepts pushes, drives the RAM write port,
// publishes the Gray write pointer and derives full/almost_full/level from the synced read pointer.
module fifo_wr_ctrl
  import fifo_pkg::*;
#(
  parameter int DEPTH       = 16,
  parameter int AF_THRESH   = 14,
  parameter int SYNC_STAGES = 2,
  localparam int AW         = fifo_aw(DEPTH)
) (
  input  logic          wr_clk,
  input  logic          rst_n,
  input  logic          wr_req,
  input  logic [AW:0]   rd_gptr_async,
  output logic          ram_wr_en,
  output logic [AW-1:0] ram_wr_addr,
  output logic [AW:0]   wr_gptr,
  output logic          full,
  output logic          almost_full,
  output logic [AW:0]   wr_level,
  output logic          overflow
);

  // Full pattern: read pointer with its top two bits inverted (both bits when AW = 1).
  localparam int          FM        = 3 << (AW - 1);
  localparam logic [AW:0] FULL_MASK = FM[AW:0];
  localparam logic [AW:0] AF_T      = AF_THRESH[AW:0];

  logic [AW:0] wr_bin, wr_bin_nxt, wr_gray_nxt, rq_gptr, rq_bin, level_nxt;
  logic [31:0] gray32, rbin32;
  logic        push;

  sync_bus #(.WIDTH(AW + 1), .STAGES(SYNC_STAGES)) u_rq_sync (
    .clk   (wr_clk),
    .rst_n (rst_n),
    .d     (rd_gptr_async),
    .q     (rq_gptr)
  );

  assign push        = wr_req & ~full;
  assign ram_wr_en   = push;
  assign ram_wr_addr = wr_bin[AW-1:0];

  assign wr_bin_nxt  = wr_bin + {{AW{1'b0}}, push};
  assign gray32      = bin2gray(32'(wr_bin_nxt));
  assign wr_gray_nxt = gray32[AW:0];
  assign rbin32      = gray2bin(32'(rq_gptr));
  assign rq_bin      = rbin32[AW:0];
  assign level_nxt   = wr_bin_nxt - rq_bin;

  always_ff @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_bin      <= '0;
      wr_gptr     <= '0;
      full        <= 1'b0;
      almost_full <= 1'b0;
      wr_level    <= '0;
      overflow    <= 1'b0;
    end else begin
      wr_bin      <= wr_bin_nxt;
      wr_gptr     <= wr_gray_nxt;
      full        <= (wr_gray_nxt == (rq_gptr ^ FULL_MASK));
      almost_full <= (level_nxt >= AF_T);
      wr_level    <= level_nxt;
      overflow    <= wr_req & full;
    end
  end

endmodule

// File: tb/tb_fifo_wr_ctrl.sv
// Directed bench for fifo_wr_ctrl: occupancy-count model checked every cycle plus literal pins.
module tb_fifo_wr_ctrl;

  localparam int DEPTH = 16, AFT = 14, SS = 2, AW = 4;

  logic          wr_clk = 1'b0, rst_n = 1'b0, wr_req = 1'b0;
  logic [AW:0]   rd_gptr_async;
  logic          ram_wr_en, full, almost_full, overflow;
  logic [AW-1:0] ram_wr_addr;
  logic [AW:0]   wr_gptr, wr_level;

  int total = 0, bad = 0;
  int rd_cnt = 0;

  // Model state: push count and delayed view of read count (all mod 32)
  int m_wr = 0, m_level = 0, h0 = 0, h1 = 0;
  bit m_full = 0, m_af = 0, m_ovf = 0;
  logic [AW:0] last_g = '0;

  function automatic int gray(input int b);
    return b ^ (b >> 1);
  endfunction

  assign rd_gptr_async = 5'(gray(rd_cnt % 32));

  fifo_wr_ctrl #(.DEPTH(DEPTH), .AF_THRESH(AFT), .SYNC_STAGES(SS)) dut (
    .wr_clk(wr_clk), .rst_n(rst_n), .wr_req(wr_req), .rd_gptr_async(rd_gptr_async),
    .ram_wr_en(ram_wr_en), .ram_wr_addr(ram_wr_addr), .wr_gptr(wr_gptr), .full(full),
    .almost_full(almost_full), .wr_level(wr_level), .overflow(overflow)
  );

  always #5 wr_clk = ~wr_clk;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
    end
  endtask

  // Model: occupancy = pushes - reads seen through the synchronizer (SS edges late)
  always @(posedge wr_clk or negedge rst_n) begin
    if (!rst_n) begin
      m_wr = 0; m_level = 0; h0 = 0; h1 = 0;
      m_full = 0; m_af = 0; m_ovf = 0;
    end else begin
      int seen;
      seen  = h1;
      h1    = h0;
      h0    = rd_cnt % 32;
      m_ovf = wr_req && m_full;
      if (wr_req && !m_full) m_wr = (m_wr + 1) % 32;
      m_level = (m_wr - seen + 32) % 32;
      m_full  = (m_level == DEPTH);
      m_af    = (m_level >= AFT);
    end
  end

  always @(negedge wr_clk) begin
    #1;
    if (!rst_n) begin
      check("rst_outputs", {ram_wr_en, full, almost_full, overflow, wr_gptr, wr_level}, 0);
      last_g = '0;
    end else begin
      check("ram_wr_en",   ram_wr_en,   int'(wr_req && !m_full));
      check("ram_wr_addr", ram_wr_addr, m_wr % DEPTH);
      check("wr_gptr",     wr_gptr,     gray(m_wr));
      check("full",        full,        m_full);
      check("almost_full", almost_full, m_af);
      check("wr_level",    wr_level,    m_level);
      check("overflow",    overflow,    m_ovf);
      if (wr_gptr != last_g) check("gray_hamming", $countones(wr_gptr ^ last_g), 1);
      last_g = wr_gptr;
    end
  end

  task automatic cyc(input bit req);
    @(negedge wr_clk);
    wr_req = req;
  endtask

  initial begin
    // Reset, released away from the clock edge
    repeat (2) @(negedge wr_clk);
    #2 rst_n = 1'b1;
    cyc(0);
    check("post_rst_gptr", wr_gptr, 0);
    check("post_rst_full", full, 0);

    // Fill: 16 pushes
    repeat (16) cyc(1);
    @(negedge wr_clk);
    check("fill_gptr",  wr_gptr, 5'b11000);
    check("fill_level", wr_level, 16);
    check("fill_full",  full, 1);
    check("fill_af",    almost_full, 1);

    // Overflow: wr_req stays high for 3 refused cycles
    repeat (2) cyc(1);
    cyc(0);
    check("ovf_pulse", overflow, 1);
    check("ovf_gptr",  wr_gptr, 5'b11000);

    // Release 4 entries from the read side
    @(negedge wr_clk);
    rd_cnt = 4;
    @(negedge wr_clk);
    @(negedge wr_clk);
    check("release_full_held", full, 1);
    @(negedge wr_clk);
    check("release_full", full, 0);
    check("release_level", wr_level, 12);
    check("release_af", almost_full, 0);

    // Wrap: 4 more pushes with the reader tracking
    repeat (4) begin
      cyc(1);
      rd_cnt++;
    end
    cyc(0);
    repeat (4) cyc(0);
    check("wrap_gptr", wr_gptr, gray(20));

    // Reset, then 7 pushes, then reset mid-cycle
    @(negedge wr_clk);
    #2 rst_n = 1'b0;
    rd_cnt = 0;
    repeat (2) @(negedge wr_clk);
    #2 rst_n = 1'b1;
    repeat (7) cyc(1);
    @(posedge wr_clk);
    #2 wr_req = 1'b0;
    rst_n = 1'b0;
    #1;
    check("midrst_gptr",  wr_gptr, 0);
    check("midrst_level", wr_level, 0);
    check("midrst_flags", {full, almost_full, overflow, ram_wr_en}, 0);
    @(negedge wr_clk);
    #2 rst_n = 1'b1;
    cyc(1);
    #1;
    check("first_push_addr", ram_wr_addr, 0);
    check("first_push_en",   ram_wr_en, 1);
    cyc(0);
    repeat (3) cyc(0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
